// File: rtl/ysyx_wb_unit.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_wb_unit
// Purpose  : GPR writeback arbiter (LSU priority, ALU starvation guard),
//            registered write port and per-register pending scoreboard.
// Revision : 1.0
// ============================================================================
module ysyx_wb_unit #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            rf_wr_en,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic            busy1,
    output logic            busy2
);

    localparam logic [2:0] C_STARVE_LIMIT = 3'(STARVE_MAX);

    logic [31:0]     pending_q, pending_d;
    logic [2:0]      starve_q, starve_d;
    logic            rf_wr_en_q, rf_wr_en_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            alu_gnt, lsu_gnt, xfer, iss_ok;
    logic [4:0]      xfer_rd;
    logic [XLEN-1:0] xfer_data;

    always_comb begin
        alu_gnt   = rst_n && alu_valid && (!lsu_valid || (starve_q >= C_STARVE_LIMIT));
        lsu_gnt   = rst_n && lsu_valid && !alu_gnt;
        xfer      = alu_gnt || lsu_gnt;
        xfer_rd   = lsu_gnt ? lsu_rd   : alu_rd;
        xfer_data = lsu_gnt ? lsu_data : alu_data;

        // Starve counts consecutive ALU losses; any other outcome restarts it.
        starve_d  = (lsu_gnt && alu_valid) ? starve_q + 3'd1 : 3'd0;

        iss_ok    = rst_n && !((iss_rd != 5'd0) && pending_q[iss_rd]);

        // A pending clear and a set of the same register never coincide
        // because iss_ok is low while that register is still pending.
        pending_d = pending_q;
        if (rf_wr_en_q) begin
            pending_d[waddr_q] = 1'b0;
        end
        if (iss_valid && iss_ok && (iss_rd != 5'd0)) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        rf_wr_en_d = xfer && (xfer_rd != 5'd0);
        waddr_d    = xfer ? xfer_rd   : waddr_q;
        wdata_d    = xfer ? xfer_data : wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            starve_q   <= '0;
            rf_wr_en_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            starve_q   <= starve_d;
            rf_wr_en_q <= rf_wr_en_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign iss_ready = iss_ok;
    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;
    assign rf_wr_en  = rf_wr_en_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy1     = pending_q[raddr1];
    assign busy2     = pending_q[raddr2];

endmodule
`default_nettype wire
